// File: rtl/viterbi_sequencer.sv
// Trellis walk controller for the Viterbi POS tagger: steps state/word indices and
// drives the accumulate/commit/swap strobes plus the backpointer stack push/pop.
module viterbi_sequencer #(
  parameter int N_STATES  = 4,
  parameter int IDX_W     = 2,
  parameter int MAX_WORDS = 16,
  parameter int WORD_W    = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              endline,
  input  logic              error,
  input  logic              greedy,
  input  logic              stack_empty,
  output logic [2:0]        state,
  output logic [IDX_W-1:0]  prev_idx,
  output logic [IDX_W-1:0]  cur_idx,
  output logic [WORD_W-1:0] word_idx,
  output logic              init_en,
  output logic              acc_en,
  output logic              acc_first,
  output logic              commit_en,
  output logic              push_en,
  output logic              swap_en,
  output logic              pop_en,
  output logic              busy,
  output logic              done,
  output logic              err_flag,
  output logic              overflow
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    INIT      = 3'd1,
    ACC       = 3'd2,
    COMMIT    = 3'd3,
    NEXT_WORD = 3'd4,
    BACKTRACK = 3'd5,
    DONE      = 3'd6,
    ERROR     = 3'd7
  } state_t;

  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(N_STATES - 1);
  localparam logic [WORD_W-1:0] LAST_WORD = WORD_W'(MAX_WORDS - 1);

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  prev_d, cur_d;
  logic [WORD_W-1:0] word_d;
  logic              endline_seen, endl_d;
  logic              ovf_d, err_d;
  logic              mode_g, mode_d;
  logic              line_end;

  assign line_end = endline_seen | endline;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      prev_idx     <= '0;
      cur_idx      <= '0;
      word_idx     <= '0;
      endline_seen <= 1'b0;
      overflow     <= 1'b0;
      err_flag     <= 1'b0;
      mode_g       <= 1'b0;
    end else begin
      state_q      <= state_d;
      prev_idx     <= prev_d;
      cur_idx      <= cur_d;
      word_idx     <= word_d;
      endline_seen <= endl_d;
      overflow     <= ovf_d;
      err_flag     <= err_d;
      mode_g       <= mode_d;
    end
  end

  always_comb begin
    state_d = state_q;
    prev_d  = prev_idx;
    cur_d   = cur_idx;
    word_d  = word_idx;
    endl_d  = endline_seen | ((state_q != IDLE) & endline);
    ovf_d   = overflow;
    err_d   = err_flag;
    mode_d  = mode_g;
    if ((state_q != IDLE) && error) begin
      state_d = ERROR;
      err_d   = 1'b1;
    end else begin
      unique case (state_q)
        IDLE, ERROR: begin
          // A restart out of ERROR behaves exactly like a fresh start from IDLE.
          if (start) begin
            state_d = INIT;
            prev_d  = '0;
            cur_d   = '0;
            word_d  = '0;
            endl_d  = 1'b0;
            ovf_d   = 1'b0;
            err_d   = 1'b0;
            mode_d  = greedy;
          end
        end
        INIT: begin
          if (cur_idx == LAST_IDX) begin
            if (line_end) begin
              state_d = BACKTRACK;
            end else begin
              state_d = ACC;
              word_d  = WORD_W'(1);
              cur_d   = '0;
              prev_d  = '0;
            end
          end else begin
            cur_d = cur_idx + 1'b1;
          end
        end
        ACC: begin
          if (prev_idx == LAST_IDX) state_d = COMMIT;
          else                      prev_d  = prev_idx + 1'b1;
        end
        COMMIT: begin
          prev_d = '0;
          if (cur_idx == LAST_IDX) begin
            cur_d   = '0;
            state_d = NEXT_WORD;
          end else begin
            cur_d   = cur_idx + 1'b1;
            state_d = ACC;
          end
        end
        NEXT_WORD: begin
          if (line_end) begin
            state_d = BACKTRACK;
          end else if (word_idx == LAST_WORD) begin
            ovf_d   = 1'b1;
            state_d = BACKTRACK;
          end else begin
            word_d  = word_idx + 1'b1;
            state_d = ACC;
          end
        end
        BACKTRACK: begin
          if (stack_empty || mode_g) state_d = DONE;
        end
        DONE: state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Strobes are pure decodes of the registered state, so reset kills them at once.
  assign state     = state_q;
  assign busy      = (state_q != IDLE);
  assign init_en   = (state_q == INIT);
  assign acc_en    = (state_q == ACC);
  assign acc_first = (state_q == ACC) && (prev_idx == '0);
  assign commit_en = (state_q == COMMIT);
  assign push_en   = (state_q == COMMIT) && !mode_g;
  assign swap_en   = (state_q == NEXT_WORD);
  assign pop_en    = (state_q == BACKTRACK) && !stack_empty && !mode_g;
  assign done      = (state_q == DONE);

endmodule

// File: tb/tb_viterbi_sequencer.sv
// Randomised bench for viterbi_sequencer: a behavioural stack model feeds stack_empty and
// each line is checked against trellis-walk counts and index order derived from endline timing.
module tb_viterbi_sequencer;
  localparam int N  = 4;
  localparam int IW = 2;
  localparam int MW = 16;
  localparam int WW = 4;
  localparam int L  = N * (N + 1) + 1;

  logic clk = 1'b0, reset = 1'b0;
  logic start = 1'b0, endline = 1'b0, error = 1'b0, greedy = 1'b0;
  logic stack_empty;
  logic [2:0] state;
  logic [IW-1:0] prev_idx, cur_idx;
  logic [WW-1:0] word_idx;
  logic init_en, acc_en, acc_first, commit_en, push_en, swap_en, pop_en;
  logic busy, done, err_flag, overflow;

  int n_tests = 0;
  int n_fail  = 0;
  int depth;

  viterbi_sequencer #(.N_STATES(N), .IDX_W(IW), .MAX_WORDS(MW), .WORD_W(WW)) dut (
    .clk(clk), .reset(reset), .start(start), .endline(endline), .error(error),
    .greedy(greedy), .stack_empty(stack_empty), .state(state), .prev_idx(prev_idx),
    .cur_idx(cur_idx), .word_idx(word_idx), .init_en(init_en), .acc_en(acc_en),
    .acc_first(acc_first), .commit_en(commit_en), .push_en(push_en), .swap_en(swap_en),
    .pop_en(pop_en), .busy(busy), .done(done), .err_flag(err_flag), .overflow(overflow)
  );

  always #5 clk = ~clk;

  assign stack_empty = (depth == 0);
  always @(posedge clk or negedge reset) begin
    if (!reset) depth <= 0;
    else        depth <= depth + (push_en ? 1 : 0) - (pop_en ? 1 : 0);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] strobes();
    return {init_en, acc_en, acc_first, commit_en, push_en, swap_en, pop_en, done};
  endfunction

  task automatic wait_state(input string tag, input logic [2:0] s);
    int k = 0;
    while (state !== s && k < 300) begin
      @(posedge clk); #1; k++;
    end
    check(tag, {29'd0, state}, {29'd0, s});
  endtask

  // One line: endline pulses in cycle t after start (t<0: never).
  task automatic run_line(input bit g, input int t);
    int w_exp, pops_exp, done_exp, cyc, done_cyc;
    bit ovf_exp;
    int q[$];
    int n_init = 0, n_acc = 0, n_first = 0, n_commit = 0, n_push = 0, n_swap = 0, n_pop = 0;
    logic ovf_seen = 1'b0;

    if (t < 0 || t >= N + (MW - 1) * L) begin
      w_exp = MW - 1; ovf_exp = 1'b1;
    end else if (t < N) begin
      w_exp = 0; ovf_exp = 1'b0;
    end else begin
      w_exp = (t - N) / L + 1; ovf_exp = 1'b0;
    end
    pops_exp = g ? 0 : w_exp * N;
    done_exp = N + w_exp * L + pops_exp + 1;
    for (int w = 1; w <= w_exp; w++)
      for (int c = 0; c < N; c++)
        for (int p = 0; p < N; p++)
          q.push_back(w * 256 + c * 16 + p);

    start = 1'b1; greedy = g;
    @(posedge clk); #1;
    start = 1'b0; greedy = 1'($urandom);
    cyc = 0; done_cyc = -1;
    while (cyc < 3000 && done_cyc < 0) begin
      endline = (cyc == t);
      @(negedge clk);
      if (init_en) begin
        check("init_cur", {30'd0, cur_idx}, n_init);
        n_init++;
      end
      if (acc_en) begin
        n_acc++;
        if (q.size() == 0) begin
          check("acc_extra", 1, 0);
        end else begin
          int e = q.pop_front();
          check("acc_pos", word_idx * 256 + cur_idx * 16 + prev_idx, e);
          check("acc_first", {31'd0, acc_first}, {31'd0, (e % 16) == 0});
        end
      end
      if (acc_first) n_first++;
      if (commit_en) n_commit++;
      if (push_en)   n_push++;
      if (swap_en)   n_swap++;
      if (pop_en)    n_pop++;
      if (done) begin
        done_cyc = cyc;
        ovf_seen = overflow;
      end
      @(posedge clk); #1;
      cyc++;
    end
    endline = 1'b0;
    check("done_seen", {31'd0, done_cyc >= 0}, 1);
    check("done_cycle", done_cyc, done_exp);
    check("done_pulse", {31'd0, done}, 0);
    check("back_idle", {29'd0, state}, 0);
    check("n_init", n_init, N);
    check("n_acc", n_acc, w_exp * N * N);
    check("n_first", n_first, w_exp * N);
    check("n_commit", n_commit, w_exp * N);
    check("n_push", n_push, g ? 0 : w_exp * N);
    check("n_swap", n_swap, w_exp);
    check("n_pop", n_pop, pops_exp);
    check("overflow", {31'd0, ovf_seen}, {31'd0, ovf_exp});
    check("stack_drained", depth, g ? w_exp * N * 0 : 0);
  endtask

  initial begin
    for (int i = 0; i < 6; i++) begin
      start = 1'($urandom); endline = 1'($urandom); error = 1'($urandom); greedy = 1'($urandom);
      @(negedge clk);
      check("reset_out", {13'd0, state, prev_idx, cur_idx, word_idx, strobes(), busy, err_flag, overflow}, 0);
    end
    start = 1'b0; endline = 1'b0; error = 1'b0; greedy = 1'b0;
    @(posedge clk); #1; reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("idle_after_rst", {28'd0, state, busy}, 0);

    error = 1'b1;
    @(posedge clk); #1; error = 1'b0;
    check("idle_err_ign", {28'd0, state, err_flag}, 0);

    run_line(1'b0, N + 5);
    run_line(1'b0, 2);
    run_line(1'b0, -1);
    run_line(1'b1, -1);
    run_line(1'b1, N + L + 3);
    run_line(1'b0, N + 2 * L - 1);
    for (int i = 0; i < 8; i++) begin
      int tt = ($urandom_range(0, 3) == 0) ? -1 : int'($urandom_range(0, N + (MW - 1) * L + 10));
      run_line(1'($urandom), tt);
    end

    start = 1'b1; greedy = 1'b0;
    @(posedge clk); #1; start = 1'b0;
    wait_state("reach_acc", 3'd2);
    error = 1'b1;
    @(posedge clk); #1; error = 1'b0;
    check("err_state", {29'd0, state}, 7);
    check("err_flag", {31'd0, err_flag}, 1);
    check("err_strobes", {24'd0, strobes()}, 0);
    check("err_busy", {31'd0, busy}, 1);
    repeat (2) @(posedge clk);
    #1;
    check("err_hold", {29'd0, state}, 7);
    start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    check("restart_init", {29'd0, state}, 1);
    check("restart_errclr", {31'd0, err_flag}, 0);
    wait_state("reach_commit", 3'd3);
    #2; reset = 1'b0; #1;
    check("async_rst_state", {29'd0, state}, 0);
    check("async_rst_strb", {24'd0, strobes()}, 0);
    @(posedge clk); #1; reset = 1'b1;
    @(posedge clk); #1;
    run_line(1'b0, N + L + 7);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/viterbi_sequencer.md
# viterbi_sequencer

Parametrised trellis sequencer for the Viterbi POS-tagging datapath, the successor to the fixed-size HMM controller. It walks an N_STATES × N_STATES trellis word by word and drives the HMM-matrix index counters, the accumulate/compare/commit strobes, the posibility-bank swap, and the backpointer stack push/pop. It adds a MAX_WORDS overflow guard and a greedy mode that skips backtracking. It sits between the word/key front end and the posibility/stack datapath.

## Interface
- N_STATES, 4, number of POS states (≥2)
- IDX_W, 2, width of state indices (2^IDX_W ≥ N_STATES)
- MAX_WORDS, 16, maximum words per line (≥2)
- WORD_W, 4, width of word counter (2^WORD_W ≥ MAX_WORDS)
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low reset
- start  in  1  level; sampled only in IDLE
- endline  in  1  pulse/level; end of current line, latched while busy
- error  in  1  datapath/source error, highest priority
- greedy  in  1  sampled with start; 1 = skip backtrack
- stack_empty  in  1  backpointer stack empty flag
- state  out  3  FSM state code
- prev_idx  out  IDX_W  previous-state index (transition row)
- cur_idx  out  IDX_W  current-state index (emission/transition column)
- word_idx  out  WORD_W  current word position
- init_en  out  1  load initial×emission for cur_idx
- acc_en  out  1  evaluate candidate prev_idx→cur_idx
- acc_first  out  1  with acc_en: load instead of compare (prev_idx==0)
- commit_en  out  1  write best value for cur_idx into the new bank
- push_en  out  1  push best backpointer
- swap_en  out  1  swap old/new posibility banks
- pop_en  out  1  pop backpointer during backtrack
- busy  out  1  FSM not in IDLE
- done  out  1  one-cycle completion pulse
- err_flag  out  1  sticky error indicator
- overflow  out  1  sticky; line truncated at MAX_WORDS

## Operation
- State codes: IDLE=0, INIT=1, ACC=2, COMMIT=3, NEXT_WORD=4, BACKTRACK=5, DONE=6, ERROR=7.
- Reset value of all outputs and registers is 0; state=IDLE.
- IDLE: start=1 → INIT. Clear counters, endline_seen, overflow, and err_flag. Latch greedy into mode_g.
- INIT: init_en=1 for one cycle each as cur_idx runs 0..N_STATES-1. On the last cycle:
  - if endline_seen|endline → BACKTRACK;
  - else word_idx←1, cur_idx←0, prev_idx←0 → ACC.
- ACC: acc_en=1 every cycle; acc_first=1 when prev_idx==0; prev_idx increments. On prev_idx==N_STATES-1 → COMMIT.
- COMMIT: commit_en=1 and push_en=1 (push_en=0 when mode_g) for one cycle. Then prev_idx←0.
  - cur_idx==N_STATES-1 → cur_idx←0, go NEXT_WORD;
  - else cur_idx++ → ACC.
- NEXT_WORD: swap_en=1 for one cycle.
  - If endline_seen|endline → BACKTRACK.
  - Else if word_idx==MAX_WORDS-1 → overflow←1, BACKTRACK.
  - Else word_idx++ → ACC.
- BACKTRACK: pop_en = ~stack_empty & ~mode_g. When stack_empty or mode_g → DONE.
- DONE: done=1 for one cycle → IDLE.
- ERROR: entered from any non-IDLE state when error=1; sets err_flag=1 and drops every strobe. Stays in ERROR until start=1, which restarts like IDLE→INIT (clears err_flag). error in IDLE is ignored.
- endline_seen is set by endline=1 in any busy state and cleared on entry to INIT.
- Priority per cycle: reset > error > state transition. start while busy is ignored.
- Counters wrap never: each is bounded by its terminal compare.

## Timing
- All outputs are registered state decodes; strobes are valid in the cycle the FSM is in that state.
- start sampled at edge k → INIT during cycle k+1.
- Cycles per line of W words (non-greedy, P pops):
  - INIT: N_STATES
  - each subsequent word: N_STATES·(N_STATES+1) + 1
  - BACKTRACK: P + 1
  - DONE: 1
- done is high exactly one cycle, immediately after the BACKTRACK cycle that sees stack_empty=1.
- Reset asserted mid-line forces IDLE asynchronously; all strobes drop immediately.

## Test plan
- Reset: hold reset=0 with random inputs → all outputs 0, state=0. Release → still IDLE with start=0.
- N_STATES=4, start, endline pulse during word 1, bench stack empties after 4 pops:
  - INIT 4 cycles; ACC 16 acc_en cycles with acc_first on each prev_idx==0;
  - 4 commit_en/push_en; one swap_en; 4 pop_en; done one cycle later; no overflow.
- Endline during INIT → BACKTRACK with stack_empty=1 → done; zero acc_en and push_en.
- No endline, MAX_WORDS=16 → after word_idx=15 swap, overflow=1, BACKTRACK entered, done eventually. Only 15 words are accumulated.
- greedy=1 at start → push_en and pop_en never high; done the cycle after the final BACKTRACK entry.
- error=1 in ACC → next cycle state=7, err_flag=1, strobes 0. start=1 later → INIT, err_flag=0. Reset=0 mid-COMMIT → IDLE immediately.
